// File: rtl/shift_actuator_responder_pkg.sv
// Shared definitions for the shift actuator responder: FSM state codes, gear type
// and a small helper used to size the shared cycle counter.
package shift_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t FIRE_UP   = 3'd1;
  localparam state_t FIRE_DOWN = 3'd2;
  localparam state_t FIRE_NEU  = 3'd3;
  localparam state_t SETTLE    = 3'd4;

  typedef logic [2:0] gear_t;

  localparam gear_t GEAR_N = 3'd0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/shift_actuator_responder_req_edge_detect.sv
// Rising-edge detector for the three shifter request levels, with one-cycle history.
module req_edge_detect (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  output logic [2:0] req_rise
);

  logic [2:0] req_q;
  logic       armed;

  // The first cycle after reset only loads history, so a level already high then is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 3'b000;
      armed <= 1'b0;
    end else begin
      req_q <= req;
      armed <= 1'b1;
    end
  end

  assign req_rise = armed ? (req & ~req_q) : 3'b000;

endmodule

// File: rtl/shift_actuator_responder.sv
// Turns shifter request edges into timed solenoid pulses and tracks the engaged gear.
// Optional ignition cut during upshifts is enabled with `define SHIFT_IGN_CUT_EN.
module shift_actuator_responder
  import shift_pkg::*;
#(
  parameter int PULSE_CYCLES   = 2_500_000,
  parameter int NEUTRAL_CYCLES = 1_000_000,
  parameter int SETTLE_CYCLES  = 5_000_000,
  parameter int NUM_GEARS      = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        up_req,
  input  logic        down_req,
  input  logic        neutral_req,
  output logic        sol_up,
  output logic        sol_down,
  output logic        busy,
  output logic        shift_done,
  output logic        reject,
  output logic [2:0]  gear,
  output logic        ign_cut
);

  localparam int CNT_W = $clog2(max3(PULSE_CYCLES, NEUTRAL_CYCLES, SETTLE_CYCLES)) + 1;

  localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] NEUTRAL_LOAD = CNT_W'(NEUTRAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);

  logic [2:0]       req_edge;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  gear_t            gear_q;
  logic             reject_q;

  req_edge_detect u_req_edge_detect (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({neutral_req, down_req, up_req}),
    .req_rise (req_edge)
  );

  // Counter is reloaded on every state entry and counts down to the last cycle of that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      gear_q   <= GEAR_N;
      reject_q <= 1'b0;
    end else begin
      reject_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_edge != 3'b000) begin
            if (req_edge == 3'b001 && gear_q < gear_t'(NUM_GEARS)) begin
              state <= FIRE_UP;
              cnt   <= PULSE_LOAD;
            end else if (req_edge == 3'b010 && gear_q >= gear_t'(2)) begin
              state <= FIRE_DOWN;
              cnt   <= PULSE_LOAD;
            end else if (req_edge == 3'b100 && gear_q == gear_t'(1)) begin
              state <= FIRE_NEU;
              cnt   <= NEUTRAL_LOAD;
            end else begin
              reject_q <= 1'b1;
            end
          end
        end
        FIRE_UP, FIRE_DOWN, FIRE_NEU: begin
          if (cnt == '0) begin
            state <= SETTLE;
            cnt   <= SETTLE_LOAD;
            case (state)
              FIRE_UP:   gear_q <= gear_q + 3'd1;
              FIRE_DOWN: gear_q <= gear_q - 3'd1;
              default:   gear_q <= GEAR_N;
            endcase
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign sol_up     = (state == FIRE_UP);
  assign sol_down   = (state == FIRE_DOWN) || (state == FIRE_NEU);
  assign busy       = (state != IDLE);
  assign shift_done = (state == SETTLE) && (cnt == '0);
  assign reject     = reject_q;
  assign gear       = gear_q;

`ifdef SHIFT_IGN_CUT_EN
  assign ign_cut = sol_up;
`else
  assign ign_cut = 1'b0;
`endif

endmodule

// File: tb/tb_shift_actuator_responder.sv
// Self-checking bench: fixed vector table, hand-written corner sequences and random
// request traffic compared against a transaction-level timing model.
module tb_shift_actuator_responder;

  localparam int P  = 4;
  localparam int NC = 2;
  localparam int S  = 3;
  localparam int G  = 6;

  localparam bit IGN =
`ifdef SHIFT_IGN_CUT_EN
    1'b1;
`else
    1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       up_req = 1'b0;
  logic       down_req = 1'b0;
  logic       neutral_req = 1'b0;
  logic       sol_up, sol_down, busy, shift_done, reject, ign_cut;
  logic [2:0] gear;

  shift_actuator_responder #(
    .PULSE_CYCLES   (P),
    .NEUTRAL_CYCLES (NC),
    .SETTLE_CYCLES  (S),
    .NUM_GEARS      (G)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .up_req      (up_req),
    .down_req    (down_req),
    .neutral_req (neutral_req),
    .sol_up      (sol_up),
    .sol_down    (sol_down),
    .busy        (busy),
    .shift_done  (shift_done),
    .reject      (reject),
    .gear        (gear),
    .ign_cut     (ign_cut)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: one accepted shift is a window of cycles; everything is derived from its bounds.
  int         cyc = 0;
  logic [2:0] m_prev = 3'b000;
  bit         m_armed = 1'b0;
  bit         t_valid = 1'b0;
  bit         t_up = 1'b0;
  int         t_start = 0, t_pulse_end = 0, t_end = 0;
  logic [2:0] m_base = 3'd0, m_target = 3'd0;
  int         rej_cyc = -1;

  typedef struct packed {
    logic [2:0] req;
    logic       su, sd, bz, dn, rj;
    logic [2:0] gr;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [2:0] expGear();
    return (t_valid && cyc > t_pulse_end) ? m_target : m_base;
  endfunction

  function automatic logic [8:0] expOut();
    logic act, su, sd, dn, rj;
    act = t_valid && cyc >= t_start && cyc <= t_end;
    su  = act && t_up && cyc <= t_pulse_end;
    sd  = act && !t_up && cyc <= t_pulse_end;
    dn  = act && cyc == t_end;
    rj  = (cyc == rej_cyc);
    return {su, sd, act, dn, rj, (IGN & su), expGear()};
  endfunction

  task automatic startTxn(input bit up, input int len, input logic [2:0] g, input logic [2:0] tgt);
    t_valid     = 1'b1;
    t_up        = up;
    m_base      = g;
    m_target    = tgt;
    t_start     = cyc + 1;
    t_pulse_end = cyc + len;
    t_end       = cyc + len + S;
  endtask

  task automatic modelCommit(input logic [2:0] req);
    logic [2:0] edges;
    logic [2:0] g;
    edges = m_armed ? (req & ~m_prev) : 3'b000;
    if (edges != 3'b000 && (!t_valid || cyc > t_end)) begin
      g = expGear();
      if (edges == 3'b001 && g < 3'(G))        startTxn(1'b1, P, g, g + 3'd1);
      else if (edges == 3'b010 && g >= 3'd2)   startTxn(1'b0, P, g, g - 3'd1);
      else if (edges == 3'b100 && g == 3'd1)   startTxn(1'b0, NC, g, 3'd0);
      else                                     rej_cyc = cyc + 1;
    end
    m_prev  = req;
    m_armed = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [8:0] exp);
    logic [8:0] act;
    act = {sol_up, sol_down, busy, shift_done, reject, ign_cut, gear};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %b, expected %b (su,sd,busy,done,rej,ign,gear)",
               tag, cyc, act, exp);
    end
  endtask

  task automatic checkVal(input string tag, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] req, input bit use_exp, input logic [8:0] exp,
                               input string tag);
    {neutral_req, down_req, up_req} = req;
    @(negedge clk);
    checkOutput(tag, use_exp ? exp : expOut());
    modelCommit(req);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic doReset(input string tag);
    #2 rst_n = 1'b0;
    #1 checkOutput(tag, 9'b0);
    t_valid = 1'b0;
    m_base  = 3'd0;
    rej_cyc = -1;
    m_prev  = 3'b000;
    m_armed = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic doShift(input logic [2:0] req, input string tag);
    applyStimulus(req, 1'b0, 9'b0, tag);
    for (int i = 0; i < P + S + 3; i++) applyStimulus(3'b000, 1'b0, 9'b0, tag);
  endtask

  task automatic addRow(input logic [2:0] req, input logic su, input logic sd, input logic bz,
                        input logic dn, input logic rj, input logic [2:0] gr);
    vec_t v;
    v = '{req: req, su: su, sd: sd, bz: bz, dn: dn, rj: rj, gr: gr};
    tbl.push_back(v);
  endtask

  initial begin
    // Upshift N->1, down reject in 1, neutral 1->N, down reject in N.
    addRow(3'b000, 0, 0, 0, 0, 0, 3'd0);
    addRow(3'b001, 0, 0, 0, 0, 0, 3'd0);
    addRow(3'b001, 1, 0, 1, 0, 0, 3'd0);
    addRow(3'b001, 1, 0, 1, 0, 0, 3'd0);
    addRow(3'b000, 1, 0, 1, 0, 0, 3'd0);
    addRow(3'b000, 1, 0, 1, 0, 0, 3'd0);
    addRow(3'b000, 0, 0, 1, 0, 0, 3'd1);
    addRow(3'b000, 0, 0, 1, 0, 0, 3'd1);
    addRow(3'b000, 0, 0, 1, 1, 0, 3'd1);
    addRow(3'b000, 0, 0, 0, 0, 0, 3'd1);
    addRow(3'b010, 0, 0, 0, 0, 0, 3'd1);
    addRow(3'b000, 0, 0, 0, 0, 1, 3'd1);
    addRow(3'b000, 0, 0, 0, 0, 0, 3'd1);
    addRow(3'b100, 0, 0, 0, 0, 0, 3'd1);
    addRow(3'b100, 0, 1, 1, 0, 0, 3'd1);
    addRow(3'b000, 0, 1, 1, 0, 0, 3'd1);
    addRow(3'b000, 0, 0, 1, 0, 0, 3'd0);
    addRow(3'b000, 0, 0, 1, 0, 0, 3'd0);
    addRow(3'b000, 0, 0, 1, 1, 0, 3'd0);
    addRow(3'b000, 0, 0, 0, 0, 0, 3'd0);
    addRow(3'b010, 0, 0, 0, 0, 0, 3'd0);
    addRow(3'b000, 0, 0, 0, 0, 1, 3'd0);
    addRow(3'b000, 0, 0, 0, 0, 0, 3'd0);

    doReset("reset_initial");

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].req, 1'b1,
                    {tbl[i].su, tbl[i].sd, tbl[i].bz, tbl[i].dn, tbl[i].rj,
                     (IGN & tbl[i].su), tbl[i].gr},
                    $sformatf("table_row%0d", i));
    end

    // Climb to top gear, then an up edge must be refused.
    for (int i = 0; i < G; i++) doShift(3'b001, "climb");
    checkVal("gear_at_top", gear, 3'd6);
    doShift(3'b001, "up_at_top");
    checkVal("gear_after_top_reject", gear, 3'd6);

    for (int i = 0; i < 3; i++) doShift(3'b010, "descend");
    doShift(3'b100, "neutral_in_3");
    checkVal("gear_after_neutral_reject", gear, 3'd3);

    doShift(3'b010, "down_to_2");
    doShift(3'b011, "up_down_same_cycle");
    checkVal("gear_after_dual_reject", gear, 3'd2);

    // A down edge landing in SETTLE is dropped without a reject.
    applyStimulus(3'b001, 1'b0, 9'b0, "settle_ignore");
    for (int i = 0; i < P; i++) applyStimulus(3'b000, 1'b0, 9'b0, "settle_ignore");
    applyStimulus(3'b010, 1'b0, 9'b0, "settle_ignore");
    for (int i = 0; i < S + 3; i++) applyStimulus(3'b000, 1'b0, 9'b0, "settle_ignore");
    checkVal("gear_after_settle_ignore", gear, 3'd3);

    // Reset in the middle of an upshift, with the up level held through and after it.
    applyStimulus(3'b001, 1'b0, 9'b0, "reset_mid_fire");
    applyStimulus(3'b001, 1'b0, 9'b0, "reset_mid_fire");
    applyStimulus(3'b001, 1'b0, 9'b0, "reset_mid_fire");
    doReset("reset_mid_fire_async");
    for (int i = 0; i < 5; i++) applyStimulus(3'b001, 1'b0, 9'b0, "held_up_after_reset");
    checkVal("gear_after_held_up", gear, 3'd0);
    applyStimulus(3'b000, 1'b0, 9'b0, "held_up_after_reset");

    for (int i = 0; i < 600; i++) begin
      applyStimulus({($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 2) == 0)}, 1'b0, 9'b0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
